vehicle_sensor_conditioner: RTL

- Conditions the raw east-west vehicle loop sensor and produces the request input X for the traffic controller FSM.
- Sits directly upstream of the controller; its X output drives the controller's X port.
- Path: synchronise, then debounce, then count arrivals, then hold a request until the controller reports each vehicle served.
- Also flags a long-waiting request as urgent.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/sensor_debounce.sv | 122 ++++++++++++
 rtl/vehicle_sensor_conditioner.sv | 93 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the east-west vehicle request path.
package traffic_pkg;

  typedef enum logic [1:0] {
    D_LOW  = 2'b00,
    D_RISE = 2'b01,
    D_HIGH = 2'b11,
    D_FALL = 2'b10
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COUNT_W_DEF         = 4;
  localparam int MAX_WAIT_DEF        = 32;

  // Stability counter only needs to reach DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Synchronises the raw loop level, debounces it and emits one pulse per
// debounced rising edge.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_raw,
  output logic db,
  output logic arrival
);

  localparam int              CNT_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit              ONE_STAGE = (DEBOUNCE_CYCLES == 1);

  logic             s1_r;
  logic             s2_r;
  db_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_r;
  logic             db_prev_r;

  // Two-flop synchroniser for the asynchronous loop level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sensor_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce FSM; db_r is updated on the same edge the state settles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= D_LOW;
      cnt_r   <= CNT_ZERO;
      db_r    <= 1'b0;
    end else begin
      case (state_r)
        D_LOW: begin
          if (s2_r) begin
            if (ONE_STAGE) begin
              state_r <= D_HIGH;
              db_r    <= 1'b1;
              cnt_r   <= CNT_ZERO;
            end else begin
              state_r <= D_RISE;
              cnt_r   <= CNT_ONE;
            end
          end else begin
            db_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
          end
        end
        D_RISE: begin
          if (!s2_r) begin
            state_r <= D_LOW;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= D_HIGH;
            db_r    <= 1'b1;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        D_HIGH: begin
          if (!s2_r) begin
            if (ONE_STAGE) begin
              state_r <= D_LOW;
              db_r    <= 1'b0;
              cnt_r   <= CNT_ZERO;
            end else begin
              state_r <= D_FALL;
              cnt_r   <= CNT_ONE;
            end
          end else begin
            db_r  <= 1'b1;
            cnt_r <= CNT_ZERO;
          end
        end
        D_FALL: begin
          if (s2_r) begin
            state_r <= D_HIGH;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= D_LOW;
            db_r    <= 1'b0;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= D_LOW;
          db_r    <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Delayed copy of db for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_prev_r <= 1'b0;
    end else begin
      db_prev_r <= db_r;
    end
  end

  assign db      = db_r;
  assign arrival = db_r & ~db_prev_r;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Turns the debounced loop sensor into the controller request X, tracking
// unserved vehicles, long waits and dropped arrivals.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_W         = COUNT_W_DEF,
  parameter int MAX_WAIT        = MAX_WAIT_DEF,
  parameter int WAIT_W          = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sensor_raw,
  input  logic               serve,
  input  logic               flush,
  output logic               X,
  output logic [COUNT_W-1:0] pending_count,
  output logic               urgent,
  output logic               overflow
);

  localparam logic [COUNT_W-1:0] CNT_ZERO = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [WAIT_W-1:0]  TMR_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0]  TMR_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]  TMR_MAX  = WAIT_W'(MAX_WAIT);

  logic               arrival_s;
  logic               unused_db_s;
  logic               accepted_serve_s;
  logic [WAIT_W-1:0]  timer_inc_s;
  logic [COUNT_W-1:0] count_r;
  logic               overflow_r;
  logic [WAIT_W-1:0]  timer_r;
  logic               urgent_r;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .sensor_raw(sensor_raw),
    .db        (unused_db_s),
    .arrival   (arrival_s)
  );

  assign accepted_serve_s = serve & (count_r != CNT_ZERO);
  assign timer_inc_s      = timer_r + TMR_ONE;

  // Pending-vehicle counter with sticky overflow, in priority order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else if (flush) begin
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else if (arrival_s && accepted_serve_s) begin
      count_r <= count_r;
    end else if (arrival_s && (count_r == CNT_MAX)) begin
      overflow_r <= 1'b1;
    end else if (arrival_s) begin
      count_r <= count_r + CNT_ONE;
    end else if (accepted_serve_s) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Wait timer: restarts on every accepted serve, saturates at MAX_WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r  <= TMR_ZERO;
      urgent_r <= 1'b0;
    end else if (flush || !X || accepted_serve_s) begin
      timer_r  <= TMR_ZERO;
      urgent_r <= 1'b0;
    end else if (timer_r != TMR_MAX) begin
      timer_r  <= timer_inc_s;
      urgent_r <= (timer_inc_s == TMR_MAX);
    end else begin
      urgent_r <= 1'b1;
    end
  end

  assign pending_count = count_r;
  assign X             = (count_r != CNT_ZERO);
  assign urgent        = urgent_r;
  assign overflow      = overflow_r;

endmodule
